imem_dmem_port_arbiter: RTL and testbench

- Shares one single-port synchronous instruction/data memory between two requesters of the CPU core:
  - the fetch stage (IF port);
  - the load/store unit (D port).
- Sits between the core and the memory in the SOPC top level.
- Replaces the core's direct fetch connection once the memory is unified.
- Arbitrates every cycle and pipelines issue:
  - one access per cycle;
  - responses are routed back to the correct requester after a fixed memory latency.

---
 rtl/imem_dmem_port_arbiter.sv | 105 ++++++++++
 tb/tb_imem_dmem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_port_arbiter.sv
// ============================================================================
// imem_dmem_port_arbiter: shares one single-port memory between fetch and LSU.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_dmem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_wstrb,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_ce,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

   logic               r_starve_hit;
   logic [3:0]         r_starve;
   logic               w_if_wins;
   logic               w_issue;
   logic [MEM_LAT-1:0] r_vld;
   logic [MEM_LAT-1:0] r_own_d;
   logic [MEM_LAT-1:0] r_store;
   logic               w_out_vld;
   logic               w_out_own_d;
   logic               w_out_store;

   // IF only beats a pending D request once it has been refused STARVE_MAX times
   assign r_starve_hit = (r_starve == c_starve_max);
   assign w_if_wins    = if_req & (~d_req | r_starve_hit);
   assign if_gnt       = ~rst & w_if_wins;
   assign d_gnt        = ~rst & d_req & ~w_if_wins;
   assign w_issue      = if_gnt | d_gnt;

   always_ff @(posedge clk) begin
      if (rst || !if_req || if_gnt) begin
         r_starve <= 4'd0;
      end else if (!r_starve_hit) begin
         r_starve <= r_starve + 4'd1;
      end
   end

   // Response tracker: entry 0 loads in the grant cycle, the top entry is the one returning
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld   <= '0;
         r_own_d <= '0;
         r_store <= '0;
      end else begin
         r_vld   <= MEM_LAT'({r_vld, w_issue});
         r_own_d <= MEM_LAT'({r_own_d, d_gnt});
         r_store <= MEM_LAT'({r_store, d_gnt & d_we});
      end
   end

   assign w_out_vld   = r_vld[MEM_LAT-1];
   assign w_out_own_d = r_own_d[MEM_LAT-1];
   assign w_out_store = r_store[MEM_LAT-1];

   assign if_rvalid = ~rst & w_out_vld & ~w_out_own_d;
   assign d_rvalid  = ~rst & w_out_vld & w_out_own_d;
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign d_rdata   = (d_rvalid && !w_out_store) ? mem_rdata : '0;

   assign mem_ce = w_issue;

   always_comb begin
      mem_we    = 1'b0;
      mem_wstrb = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (d_gnt) begin
         mem_we    = d_we;
         mem_wstrb = d_wstrb;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else if (if_gnt) begin
         mem_addr  = if_addr;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_imem_dmem_port_arbiter.sv
// ============================================================================
// tb_imem_dmem_port_arbiter: vector table plus directed sequences, MEM_LAT 1..3.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_imem_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_wstrb;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;

   logic [2:0]  if_gnt, if_rvalid, d_gnt, d_rvalid, mem_ce, mem_we;
   logic [31:0] if_rdata [3];
   logic [31:0] d_rdata [3];
   logic [31:0] mem_addr [3];
   logic [31:0] mem_wdata [3];
   logic [31:0] mem_rdata [3];
   logic [3:0]  mem_wstrb [3];

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   // Index k runs a DUT with MEM_LAT = k+1 against its own memory model (word = C0DE_<addr>)
   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int LAT = k + 1;
      logic [31:0] mem [0:127];
      logic [31:0] line [0:LAT-1];

      assign mem_rdata[k] = line[LAT-1];

      imem_dmem_port_arbiter #(
         .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(3)
      ) u_dut (
         .clk(clk), .rst(rst),
         .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[k]),
         .if_rvalid(if_rvalid[k]), .if_rdata(if_rdata[k]),
         .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr),
         .d_wdata(d_wdata), .d_gnt(d_gnt[k]), .d_rvalid(d_rvalid[k]),
         .d_rdata(d_rdata[k]), .mem_ce(mem_ce[k]), .mem_we(mem_we[k]),
         .mem_wstrb(mem_wstrb[k]), .mem_addr(mem_addr[k]),
         .mem_wdata(mem_wdata[k]), .mem_rdata(mem_rdata[k])
      );

      always @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < 128; i++) mem[i] <= {16'hC0DE, 16'(i * 4)};
            for (int j = 0; j < LAT; j++) line[j] <= '0;
         end else begin
            line[0] <= mem_ce[k] ? mem[mem_addr[k][8:2]] : 32'h0;
            for (int j = 1; j < LAT; j++) line[j] <= line[j-1];
            if (mem_ce[k] && mem_we[k]) begin
               for (int b = 0; b < 4; b++)
                  if (mem_wstrb[k][b]) mem[mem_addr[k][8:2]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
            end
         end
      end
   end

   typedef struct {
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dw;
      logic [3:0]  ds;
      logic [31:0] da;
      logic [31:0] dwd;
      logic        eig;
      logic        edg;
      logic [31:0] eaddr;
      logic        eirv;
      logic [31:0] eird;
      logic        edrv;
      logic [31:0] edrd;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [3:0] ds, input logic [31:0] da, input logic [31:0] dwd,
                      input logic eig, input logic edg, input logic [31:0] eaddr,
                      input logic eirv, input logic [31:0] eird,
                      input logic edrv, input logic [31:0] edrd);
      vec_t v;
      v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.ds = ds; v.da = da; v.dwd = dwd;
      v.eig = eig; v.edg = edg; v.eaddr = eaddr;
      v.eirv = eirv; v.eird = eird; v.edrv = edrv; v.edrd = edrd;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [3:0] ds, input logic [31:0] da, input logic [31:0] dwd);
      if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_wstrb = ds; d_addr = da; d_wdata = dwd;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   function automatic logic [159:0] all_out(input int k);
      return {22'd0, if_gnt[k], if_rvalid[k], if_rdata[k], d_gnt[k], d_rvalid[k], d_rdata[k],
              mem_ce[k], mem_we[k], mem_wstrb[k], mem_addr[k], mem_wdata[k]};
   endfunction

   localparam logic [31:0] W = 32'hC0DE_0000;

   initial begin
      logic [68:0] exp_bus;

      // Runs on the MEM_LAT=1 instance, one row per cycle starting right after reset
      add(0, 0,     0, 0, 0,   0,     0,            0, 0, 0,     0, 0,        0, 0);
      add(1, 0,     0, 0, 0,   0,     0,            1, 0, 0,     0, 0,        0, 0);
      add(1, 4,     0, 0, 0,   0,     0,            1, 0, 4,     1, W | 0,    0, 0);
      add(1, 8,     0, 0, 0,   0,     0,            1, 0, 8,     1, W | 4,    0, 0);
      add(0, 0,     0, 0, 0,   0,     0,            0, 0, 0,     1, W | 8,    0, 0);
      add(1, 'h10,  1, 0, 0,   'h20,  0,            0, 1, 'h20,  0, 0,        0, 0);
      add(1, 'h10,  1, 0, 0,   'h20,  0,            0, 1, 'h20,  0, 0,        1, W | 'h20);
      add(1, 'h10,  1, 0, 0,   'h20,  0,            0, 1, 'h20,  0, 0,        1, W | 'h20);
      add(1, 'h10,  1, 0, 0,   'h20,  0,            1, 0, 'h10,  0, 0,        1, W | 'h20);
      add(1, 'h10,  1, 0, 0,   'h20,  0,            0, 1, 'h20,  1, W | 'h10, 0, 0);
      add(1, 'h10,  1, 0, 0,   'h20,  0,            0, 1, 'h20,  0, 0,        1, W | 'h20);
      add(1, 'h10,  1, 0, 0,   'h20,  0,            0, 1, 'h20,  0, 0,        1, W | 'h20);
      add(1, 'h10,  1, 0, 0,   'h20,  0,            1, 0, 'h10,  0, 0,        1, W | 'h20);
      add(0, 0,     0, 0, 0,   0,     0,            0, 0, 0,     1, W | 'h10, 0, 0);
      add(0, 0,     1, 1, 'hF, 'h40,  'h1234_5678,  0, 1, 'h40,  0, 0,        0, 0);
      add(1, 'h50,  1, 0, 0,   'h40,  0,            0, 1, 'h40,  0, 0,        1, 0);
      add(1, 'h50,  0, 0, 0,   0,     0,            1, 0, 'h50,  0, 0,        1, 'h1234_5678);
      add(0, 0,     0, 0, 0,   0,     0,            0, 0, 0,     1, W | 'h50, 0, 0);

      // Reset holds every output low even with both requests raised
      idle();
      rst = 1'b1;
      step();
      drive(1'b1, 32'h4, 1'b1, 1'b1, 4'hF, 32'h8, 32'hFFFF_FFFF);
      @(negedge clk);
      for (int k = 0; k < 3; k++) check($sformatf("reset_outputs_lat%0d", k + 1), all_out(k), 160'd0);
      step();
      idle();
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].ds, vecs[i].da, vecs[i].dwd);
         @(negedge clk);
         exp_bus = vecs[i].edg ? {vecs[i].dw, vecs[i].ds, vecs[i].eaddr, vecs[i].dwd}
                               : {1'b0, 4'h0, vecs[i].eaddr, 32'h0};
         check($sformatf("vec%0d_grant", i), {if_gnt[0], d_gnt[0], mem_ce[0]},
               {vecs[i].eig, vecs[i].edg, vecs[i].eig | vecs[i].edg});
         check($sformatf("vec%0d_membus", i), {mem_we[0], mem_wstrb[0], mem_addr[0], mem_wdata[0]}, exp_bus);
         check($sformatf("vec%0d_resp", i), {if_rvalid[0], if_rdata[0], d_rvalid[0], d_rdata[0]},
               {vecs[i].eirv, vecs[i].eird, vecs[i].edrv, vecs[i].edrd});
         step();
      end

      // Store then load of the same word, MEM_LAT=2
      do_reset();
      drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
      @(negedge clk);
      check("st_grant", {d_gnt[1], mem_we[1], mem_wstrb[1], mem_addr[1]}, {1'b1, 1'b1, 4'b0011, 32'h100});
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
      @(negedge clk);
      check("ld_grant_no_early_ack", {d_gnt[1], d_rvalid[1], mem_we[1]}, 3'b100);
      step();
      idle();
      @(negedge clk);
      check("st_ack", {d_rvalid[1], d_rdata[1]}, {1'b1, 32'h0});
      step();
      @(negedge clk);
      check("ld_merged_data", {d_rvalid[1], d_rdata[1]}, {1'b1, 32'hC0DE_BEEF});
      step();
      @(negedge clk);
      check("ld_single_pulse", d_rvalid[1], 1'b0);

      // Interleaved owners IF, D, IF with MEM_LAT=3
      do_reset();
      drive(1'b1, 32'h30, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h34, 32'h0);
      step();
      drive(1'b1, 32'h38, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      check("il_none_yet", {if_rvalid[2], d_rvalid[2]}, 2'b00);
      step();
      idle();
      @(negedge clk);
      check("il_first_if", {if_rvalid[2], if_rdata[2], d_rvalid[2], d_rdata[2]}, {1'b1, W | 32'h30, 1'b0, 32'h0});
      step();
      @(negedge clk);
      check("il_mid_d", {if_rvalid[2], if_rdata[2], d_rvalid[2], d_rdata[2]}, {1'b0, 32'h0, 1'b1, W | 32'h34});
      step();
      @(negedge clk);
      check("il_last_if", {if_rvalid[2], if_rdata[2], d_rvalid[2], d_rdata[2]}, {1'b1, W | 32'h38, 1'b0, 32'h0});
      step();
      @(negedge clk);
      check("il_drained", {if_rvalid[2], d_rvalid[2]}, 2'b00);

      // Reset one cycle after a D load drops it; IF is granted right after reset
      do_reset();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h60, 32'h0);
      @(negedge clk);
      check("rm_load_grant", d_gnt[2], 1'b1);
      step();
      rst = 1'b1;
      drive(1'b1, 32'h44, 1'b1, 1'b0, 4'h0, 32'h60, 32'h0);
      @(negedge clk);
      check("rm_outputs_in_reset", all_out(2), 160'd0);
      step();
      rst = 1'b0;
      drive(1'b1, 32'h44, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      check("rm_first_grant", {if_gnt[2], d_gnt[2], mem_addr[2]}, {1'b1, 1'b0, 32'h44});
      step();
      idle();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check($sformatf("rm_no_stale_%0d", c), {d_rvalid[2], if_rvalid[2]}, 2'b00);
         step();
      end
      @(negedge clk);
      check("rm_if_resp", {if_rvalid[2], if_rdata[2], d_rvalid[2]}, {1'b1, W | 32'h44, 1'b0});

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
